vga_axi_rd_arbiter: RTL and testbench
=====================================

# vga_axi_rd_arbiter

Two-master AXI4 read-channel arbiter that shares the single SoC read port between VGA scanout (master 0, high priority) and a secondary read client (master 1, e.g. a blitter or DMA). It has one burst outstanding at a time and locks the grant from address acceptance until the RLAST beat. It adds a starvation guard so master 1 always makes progress, and it checks each burst's beat count against ARLEN. It sits between the display core's AXI read outputs and the SoC interconnect slave port; the AW/W/B channels do not pass through it.

## Interface
Parameters:
- MAX_CONSEC, 4: number of consecutive master 0 grants allowed while master 1 is waiting (range 1..15).

Ports (N ∈ {0,1}; the mN_* lines each denote two ports):
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- mN_araddr  in  32  read address from master N
- mN_arlen  in  8  burst length minus 1 from master N
- mN_arsize  in  3  beat size from master N
- mN_arburst  in  2  burst type from master N
- mN_arvalid  in  1  address valid from master N
- mN_arready  out  1  address ready to master N
- mN_rdata  out  32  read data to master N
- mN_rresp  out  2  read response to master N
- mN_rvalid  out  1  data valid to master N
- mN_rlast  out  1  last beat to master N
- mN_rready  in  1  data ready from master N
- axi_araddr/axi_arlen/axi_arsize/axi_arburst  out  32/8/3/2  forwarded AR payload
- axi_arvalid  out  1  forwarded address valid
- axi_arready  in  1  slave address ready
- axi_rdata/axi_rresp  in  32/2  slave read data and response
- axi_rvalid/axi_rlast  in  1/1  slave data valid and last beat
- axi_rready  out  1  forwarded data ready
- grant_id  out  1  currently or last granted master
- busy  out  1  high in ADDR or DATA
- proto_err  out  1  sticky flag for a burst length mismatch

## Operation
- FSM states: IDLE, ADDR, DATA.
- IDLE:
  - Master 0 wins if m0_arvalid and (!m1_arvalid or starve_ctr < MAX_CONSEC).
  - Otherwise master 1 wins if m1_arvalid.
  - On a win: grant_id is registered, the granted master's arlen is latched into len_reg, beat_ctr is cleared to 0, and the FSM goes to ADDR.
  - With no request, the FSM stays in IDLE.
- starve_ctr:
  - Increments (saturating) on each master 0 grant made while m1_arvalid is high.
  - Clears on every master 1 grant.
  - Unchanged on a master 0 grant with m1_arvalid low.
- ADDR:
  - The granted master's AR payload and arvalid are driven combinationally onto axi_ar*.
  - granted mN_arready = axi_arready; the other master's arready = 0.
  - On axi_arvalid && axi_arready, the FSM goes to DATA.
- DATA:
  - axi_rready = granted mN_rready.
  - Granted mN_rvalid = axi_rvalid and mN_rlast = axi_rlast; the other master's rvalid/rlast = 0.
  - Each beat handshake increments beat_ctr (8-bit plus carry).
  - On a handshake with axi_rlast high, the FSM goes to IDLE.
  - proto_err sets if rlast arrives with beat_ctr ≠ len_reg, or if beat_ctr reaches len_reg without rlast (a beat overrun).
- Outside DATA: axi_rready = 0, both mN_rvalid = 0, and any slave beat stalls.
- mN_rdata and mN_rresp are driven by axi_rdata and axi_rresp unconditionally; only valid is gated.
- Outside ADDR: axi_arvalid = 0, both mN_arready = 0, and axi_ar* payload = 0.
- A master that drops arvalid during ADDR violates AXI; the grant is held regardless.

## Timing
- Reset values:
  - State IDLE, grant_id = 0, starve_ctr = 0, beat_ctr = 0, len_reg = 0, proto_err = 0, busy = 0.
  - All valid and ready outputs are 0.
- Arbitration latency: mN_arvalid sampled high in IDLE at cycle t → axi_arvalid high at t+1.
- Burst turnaround: RLAST handshake at cycle t → IDLE at t+1. A pending request at t+1 gives axi_arvalid at t+2, so there is a minimum 1-cycle AR gap between bursts.
- The AR and R paths are combinational pass-throughs within ADDR/DATA; this adds no latency and no skid buffer.
- Simultaneous requests with starve_ctr == MAX_CONSEC: master 1 wins, and starve_ctr = 0 at the next cycle.
- Asserting rst mid-burst aborts immediately: the FSM returns to IDLE and all outputs take their reset values. The interconnect must be reset in the same domain.

## Test plan
- Single master 0 burst, arlen = 63, axi_arready delayed 3 cycles → exactly one AR with addr = m0_araddr; 64 beats routed to m0 with rlast on beat 64; m1_rvalid never high; proto_err = 0.
- m0 and m1 request continuously, MAX_CONSEC = 4 → grant sequence 0,0,0,0,1,0,0,0,0,1…
- m1 alone, arlen = 0 → single-beat burst, grant_id = 1, then IDLE; starve_ctr stays 0.
- Slave returns rlast on beat 10 for arlen = 15 → proto_err = 1 and sticky; the FSM returns to IDLE and the next burst is served normally.
- Granted master holds rready low for 5 cycles mid-burst → axi_rready = 0 and beat_ctr frozen for those cycles; no beats are lost or duplicated.
- Assert rst during DATA at beat 20 → all outputs return to reset values asynchronously; after release the FSM is in IDLE and the next request arbitrates correctly.

Source files
------------

// File: rtl/vga_axi_rd_arbiter.sv
// vga_axi_rd_arbiter: shares one AXI4 read port between VGA scanout (m0, priority) and a secondary client (m1)
// Ports: clk/rst (async, active-high); m0_*/m1_* master AR inputs with arready back and R outputs with rready in;
//        axi_* forwarded AR payload/valid and R data/valid with rready out; grant_id (current/last grant);
//        busy (burst in flight); proto_err (sticky beat-count vs ARLEN mismatch).
module vga_axi_rd_arbiter #(
    parameter int MAX_CONSEC = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] m0_araddr,
    input  logic [7:0]  m0_arlen,
    input  logic [2:0]  m0_arsize,
    input  logic [1:0]  m0_arburst,
    input  logic        m0_arvalid,
    output logic        m0_arready,
    output logic [31:0] m0_rdata,
    output logic [1:0]  m0_rresp,
    output logic        m0_rvalid,
    output logic        m0_rlast,
    input  logic        m0_rready,
    input  logic [31:0] m1_araddr,
    input  logic [7:0]  m1_arlen,
    input  logic [2:0]  m1_arsize,
    input  logic [1:0]  m1_arburst,
    input  logic        m1_arvalid,
    output logic        m1_arready,
    output logic [31:0] m1_rdata,
    output logic [1:0]  m1_rresp,
    output logic        m1_rvalid,
    output logic        m1_rlast,
    input  logic        m1_rready,
    output logic [31:0] axi_araddr,
    output logic [7:0]  axi_arlen,
    output logic [2:0]  axi_arsize,
    output logic [1:0]  axi_arburst,
    output logic        axi_arvalid,
    input  logic        axi_arready,
    input  logic [31:0] axi_rdata,
    input  logic [1:0]  axi_rresp,
    input  logic        axi_rvalid,
    input  logic        axi_rlast,
    output logic        axi_rready,
    output logic        grant_id,
    output logic        busy,
    output logic        proto_err
);
    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
    localparam logic [3:0] MAXC = 4'(MAX_CONSEC);
    state_t     state_q;
    logic       grant_q, busy_q, err_q;
    logic [3:0] starve_q, starve_d;
    logic [8:0] beat_q, beat_d;
    logic [7:0] len_q;
    logic       pick0, pick1, in_addr, in_data, ar_hs, r_hs, len_bad;
    // m0 keeps priority until m1 has watched MAX_CONSEC m0 grants go by
    assign pick0   = m0_arvalid && (!m1_arvalid || starve_q < MAXC);
    assign pick1   = !pick0 && m1_arvalid;
    assign in_addr = state_q == ADDR;
    assign in_data = state_q == DATA;
    assign ar_hs   = axi_arvalid && axi_arready;
    assign r_hs    = axi_rvalid && axi_rready;
    always_comb begin
        starve_d = (starve_q == 4'hf) ? starve_q : starve_q + 4'd1;
        beat_d   = beat_q + 9'd1;
        // early rlast, or the expected final beat arriving without rlast
        len_bad  = axi_rlast ? (beat_q != {1'b0, len_q}) : (beat_q == {1'b0, len_q});
    end
    assign axi_araddr  = in_addr ? (grant_q ? m1_araddr  : m0_araddr)  : '0;
    assign axi_arlen   = in_addr ? (grant_q ? m1_arlen   : m0_arlen)   : '0;
    assign axi_arsize  = in_addr ? (grant_q ? m1_arsize  : m0_arsize)  : '0;
    assign axi_arburst = in_addr ? (grant_q ? m1_arburst : m0_arburst) : '0;
    assign axi_arvalid = in_addr && (grant_q ? m1_arvalid : m0_arvalid);
    assign m0_arready  = in_addr && !grant_q && axi_arready;
    assign m1_arready  = in_addr && grant_q && axi_arready;
    assign axi_rready  = in_data && (grant_q ? m1_rready : m0_rready);
    assign m0_rvalid   = in_data && !grant_q && axi_rvalid;
    assign m1_rvalid   = in_data && grant_q && axi_rvalid;
    assign m0_rlast    = in_data && !grant_q && axi_rlast;
    assign m1_rlast    = in_data && grant_q && axi_rlast;
    assign m0_rdata    = axi_rdata;
    assign m1_rdata    = axi_rdata;
    assign m0_rresp    = axi_rresp;
    assign m1_rresp    = axi_rresp;
    assign grant_id    = grant_q;
    assign busy        = busy_q;
    assign proto_err   = err_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            grant_q  <= 1'b0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
            starve_q <= '0;
            beat_q   <= '0;
            len_q    <= '0;
        end else begin
            case (state_q)
                IDLE: if (pick0 || pick1) begin
                    state_q  <= ADDR;
                    busy_q   <= 1'b1;
                    grant_q  <= pick1;
                    len_q    <= pick1 ? m1_arlen : m0_arlen;
                    beat_q   <= '0;
                    starve_q <= pick1 ? 4'd0 : (m1_arvalid ? starve_d : starve_q);
                end
                ADDR: if (ar_hs) state_q <= DATA;
                DATA: if (r_hs) begin
                    beat_q <= beat_d;
                    if (len_bad) err_q <= 1'b1;
                    if (axi_rlast) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_vga_axi_rd_arbiter.sv
// tb_vga_axi_rd_arbiter: randomized scoreboard bench for the two-master AXI read arbiter
module tb_vga_axi_rd_arbiter;
    localparam int MAXC = 4;
    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
    } req_t;

    logic clk = 1'b0, rst = 1'b1;
    logic [31:0] m0_araddr, m1_araddr, m0_rdata, m1_rdata, axi_araddr, axi_rdata;
    logic [7:0]  m0_arlen, m1_arlen, axi_arlen;
    logic [2:0]  m0_arsize, m1_arsize, axi_arsize;
    logic [1:0]  m0_arburst, m1_arburst, axi_arburst, m0_rresp, m1_rresp, axi_rresp;
    logic m0_arvalid, m0_arready, m0_rvalid, m0_rlast, m0_rready;
    logic m1_arvalid, m1_arready, m1_rvalid, m1_rlast, m1_rready;
    logic axi_arvalid, axi_arready, axi_rvalid, axi_rlast, axi_rready;
    logic grant_id, busy, proto_err;

    int checks = 0, errors = 0;
    int st_m = 0;
    int ar_delay = 0, rv_pct = 100, rr_pct = 100, stall0 = 0;
    int rcnt0 = 0, rcnt1 = 0, rvis1 = 0;
    req_t pend0[$], pend1[$], req0[$], req1[$];
    logic [45:0] exp_ar[$];
    logic [34:0] exp_r0[$], exp_r1[$];

    always #5 clk = ~clk;

    vga_axi_rd_arbiter #(.MAX_CONSEC(MAXC)) dut (
        .clk(clk), .rst(rst),
        .m0_araddr(m0_araddr), .m0_arlen(m0_arlen), .m0_arsize(m0_arsize), .m0_arburst(m0_arburst),
        .m0_arvalid(m0_arvalid), .m0_arready(m0_arready), .m0_rdata(m0_rdata), .m0_rresp(m0_rresp),
        .m0_rvalid(m0_rvalid), .m0_rlast(m0_rlast), .m0_rready(m0_rready),
        .m1_araddr(m1_araddr), .m1_arlen(m1_arlen), .m1_arsize(m1_arsize), .m1_arburst(m1_arburst),
        .m1_arvalid(m1_arvalid), .m1_arready(m1_arready), .m1_rdata(m1_rdata), .m1_rresp(m1_rresp),
        .m1_rvalid(m1_rvalid), .m1_rlast(m1_rlast), .m1_rready(m1_rready),
        .axi_araddr(axi_araddr), .axi_arlen(axi_arlen), .axi_arsize(axi_arsize), .axi_arburst(axi_arburst),
        .axi_arvalid(axi_arvalid), .axi_arready(axi_arready), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp),
        .axi_rvalid(axi_rvalid), .axi_rlast(axi_rlast), .axi_rready(axi_rready),
        .grant_id(grant_id), .busy(busy), .proto_err(proto_err)
    );

    function automatic logic [31:0] bdata(input logic [31:0] a, input int i);
        return a + 32'(i) * 32'h0001_0003;
    endfunction

    // a set address bit 31 tells the slave to end the burst early after 10 beats
    function automatic int nbeats(input req_t r);
        return r.addr[31] ? 10 : int'(r.len) + 1;
    endfunction

    function automatic req_t rnd_req(input int maxlen);
        req_t r;
        r.addr  = 32'($urandom) & 32'h7fff_fffc;
        r.len   = 8'($urandom_range(maxlen));
        r.size  = 3'($urandom_range(7));
        r.burst = 2'($urandom_range(3));
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic push_beats(input bit m, input req_t r);
        int n;
        logic [34:0] e;
        n = nbeats(r);
        for (int i = 0; i < n; i++) begin
            e = {bdata(r.addr, i), 2'(i), i == n - 1};
            if (m) exp_r1.push_back(e);
            else exp_r0.push_back(e);
        end
    endtask

    // Expected grant order: each master's queue is served in order; m0 wins unless
    // m1 is waiting and m0 has already taken MAX_CONSEC grants in a row against it.
    task automatic start_phase();
        int i0, i1;
        i0 = 0;
        i1 = 0;
        foreach (pend0[k]) push_beats(1'b0, pend0[k]);
        foreach (pend1[k]) push_beats(1'b1, pend1[k]);
        while (i0 < pend0.size() || i1 < pend1.size()) begin
            if (i0 < pend0.size() && (i1 >= pend1.size() || st_m < MAXC)) begin
                if (i1 < pend1.size() && st_m < 15) st_m++;
                exp_ar.push_back({1'b0, pend0[i0]});
                i0++;
            end else begin
                st_m = 0;
                exp_ar.push_back({1'b1, pend1[i1]});
                i1++;
            end
        end
        foreach (pend0[k]) req0.push_back(pend0[k]);
        foreach (pend1[k]) req1.push_back(pend1[k]);
        pend0.delete();
        pend1.delete();
    endtask

    task automatic wait_idle(input string nm);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            #1;
            k++;
        end while ((exp_ar.size() > 0 || exp_r0.size() > 0 || exp_r1.size() > 0 ||
                    req0.size() > 0 || req1.size() > 0 || busy) && k < 4000);
        checks++;
        if (k >= 4000) begin
            errors++;
            $display("FAIL %s_timeout: ar_left %0d r0_left %0d r1_left %0d busy %b, required all empty and idle",
                     nm, exp_ar.size(), exp_r0.size(), exp_r1.size(), busy);
            exp_ar.delete();
            exp_r0.delete();
            exp_r1.delete();
        end
    endtask

    // masters and slave: sample handshakes on the falling edge, update drives just after the rising edge
    initial begin
        logic ar_hs, r_hs, h0, h1, s_act;
        logic [31:0] c_addr, s_addr;
        logic [7:0] c_len;
        int ar_cnt, s_n, s_i;
        ar_cnt = 0; s_n = 0; s_i = 0; s_act = 1'b0; s_addr = '0;
        {m0_araddr, m0_arlen, m0_arsize, m0_arburst, m0_arvalid, m0_rready} = '0;
        {m1_araddr, m1_arlen, m1_arsize, m1_arburst, m1_arvalid, m1_rready} = '0;
        {axi_arready, axi_rdata, axi_rresp, axi_rvalid, axi_rlast} = '0;
        forever begin
            @(negedge clk);
            ar_hs  = axi_arvalid && axi_arready;
            r_hs   = axi_rvalid && axi_rready;
            h0     = m0_arvalid && m0_arready;
            h1     = m1_arvalid && m1_arready;
            c_addr = axi_araddr;
            c_len  = axi_arlen;
            @(posedge clk);
            #1;
            if (rst) begin
                req0.delete();
                req1.delete();
                s_act = 1'b0;
                ar_cnt = 0;
                stall0 = 0;
                {axi_arready, axi_rvalid, axi_rlast, m0_rready, m1_rready} = '0;
            end else begin
                if (h0 && req0.size() > 0) req0.delete(0);
                if (h1 && req1.size() > 0) req1.delete(0);
                m0_rready = stall0 > 0 ? 1'b0 : int'($urandom_range(99)) < rr_pct;
                if (stall0 > 0) stall0--;
                m1_rready = int'($urandom_range(99)) < rr_pct;
                if (ar_hs) begin
                    s_act  = 1'b1;
                    s_addr = c_addr;
                    s_n    = c_addr[31] ? 10 : int'(c_len) + 1;
                    s_i    = 0;
                end
                if (axi_arvalid) begin
                    ar_cnt++;
                    axi_arready = ar_cnt > ar_delay;
                end else begin
                    ar_cnt = 0;
                    axi_arready = 1'b0;
                end
                if (r_hs) begin
                    s_i++;
                    if (s_i == s_n) s_act = 1'b0;
                end
                if (!(axi_rvalid && !r_hs)) begin
                    if (s_act && int'($urandom_range(99)) < rv_pct) begin
                        axi_rvalid = 1'b1;
                        axi_rdata  = bdata(s_addr, s_i);
                        axi_rresp  = 2'(s_i);
                        axi_rlast  = s_i == s_n - 1;
                    end else begin
                        axi_rvalid = 1'b0;
                        axi_rlast  = 1'b0;
                    end
                end
            end
            if (req0.size() > 0) begin
                m0_arvalid = 1'b1;
                {m0_araddr, m0_arlen, m0_arsize, m0_arburst} = req0[0];
            end else begin
                m0_arvalid = 1'b0;
                {m0_araddr, m0_arlen, m0_arsize, m0_arburst} = '0;
            end
            if (req1.size() > 0) begin
                m1_arvalid = 1'b1;
                {m1_araddr, m1_arlen, m1_arsize, m1_arburst} = req1[0];
            end else begin
                m1_arvalid = 1'b0;
                {m1_araddr, m1_arlen, m1_arsize, m1_arburst} = '0;
            end
        end
    end

    // monitor: pops the scoreboard whenever the DUT presents a handshake
    initial begin
        logic [45:0] ea;
        logic [34:0] er;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (m1_rvalid) rvis1++;
                if (axi_arvalid && axi_arready) begin
                    if (exp_ar.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL ar_unexpected: got AR addr %h from grant %b, required no AR", axi_araddr, grant_id);
                    end else begin
                        ea = exp_ar.pop_front();
                        chk("ar_payload", {grant_id, axi_araddr, axi_arlen, axi_arsize, axi_arburst}, ea);
                        chk("ar_ready_route", {m1_arready, m0_arready}, ea[45] ? 2'b10 : 2'b01);
                    end
                end
                if (m0_rvalid && m0_rready) begin
                    rcnt0++;
                    if (exp_r0.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL r0_unexpected: got beat %h, required none", m0_rdata);
                    end else begin
                        er = exp_r0.pop_front();
                        chk("r0_beat", {m0_rdata, m0_rresp, m0_rlast}, er);
                    end
                end
                if (m1_rvalid && m1_rready) begin
                    rcnt1++;
                    if (exp_r1.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL r1_unexpected: got beat %h, required none", m1_rdata);
                    end else begin
                        er = exp_r1.pop_front();
                        chk("r1_beat", {m1_rdata, m1_rresp, m1_rlast}, er);
                    end
                end
                if (axi_rvalid) begin
                    chk("r_route", {m0_rvalid && m1_rvalid, axi_rready, m0_rdata, m1_rdata},
                        {1'b0, (m0_rvalid && m0_rready) || (m1_rvalid && m1_rready), axi_rdata, axi_rdata});
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1);
    end

    initial begin
        int k, saved;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_outs", {axi_arvalid, axi_rready, m0_arready, m1_arready, m0_rvalid, m1_rvalid, busy, grant_id, proto_err}, '0);
        rst = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_release", {axi_arvalid, axi_araddr, busy, grant_id, proto_err}, '0);

        // single long m0 burst, slave slow on AR
        ar_delay = 3;
        pend0.push_back('{addr: 32'h1000_0040, len: 8'd63, size: 3'd2, burst: 2'd1});
        rcnt0 = 0; rcnt1 = 0; rvis1 = 0;
        start_phase();
        @(negedge clk);
        #1;
        chk("arb_lat_pre", {axi_arvalid, busy}, 2'b00);
        @(negedge clk);
        #1;
        chk("arb_lat_post", {axi_arvalid, busy, grant_id}, 3'b110);
        wait_idle("m0_long");
        chk("m0_long_counts", {32'(rcnt0), 32'(rcnt1 + rvis1)}, {32'd64, 32'd0});
        chk("m0_long_err", proto_err, 1'b0);

        // m1 alone, single beat
        ar_delay = 0;
        pend1.push_back('{addr: 32'h2000_0000, len: 8'd0, size: 3'd2, burst: 2'd1});
        rcnt1 = 0;
        start_phase();
        wait_idle("m1_single");
        chk("m1_single", {grant_id, busy, 32'(rcnt1)}, {1'b1, 1'b0, 32'd1});

        // both masters continuously requesting
        for (int i = 0; i < 10; i++) pend0.push_back(rnd_req(3));
        for (int i = 0; i < 3; i++) pend1.push_back(rnd_req(3));
        start_phase();
        wait_idle("contend");

        // m0 holds rready low for 5 cycles mid-burst
        pend0.push_back('{addr: 32'h3000_0000, len: 8'd15, size: 3'd2, burst: 2'd1});
        rcnt0 = 0;
        start_phase();
        k = 0;
        do begin
            @(negedge clk);
            #1;
            k++;
        end while (rcnt0 < 5 && k < 200);
        chk("stall_reach", k < 200, 1'b1);
        stall0 = 5;
        saved = rcnt0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            chk("stall_rready", {axi_rready, 32'(rcnt0)}, {1'b0, 32'(saved)});
        end
        wait_idle("stall");
        chk("stall_count", rcnt0, 16);

        // slave ends a 16-beat burst after 10 beats
        pend0.push_back('{addr: 32'h8000_0100, len: 8'd15, size: 3'd2, burst: 2'd1});
        start_phase();
        wait_idle("short");
        chk("short_err", {proto_err, busy}, 2'b10);
        pend1.push_back('{addr: 32'h0000_2000, len: 8'd7, size: 3'd2, burst: 2'd1});
        rcnt1 = 0;
        start_phase();
        wait_idle("after_short");
        chk("err_sticky", {proto_err, 32'(rcnt1)}, {1'b1, 32'd8});

        // asynchronous reset in the middle of a long m1 burst
        pend1.push_back('{addr: 32'h0400_0000, len: 8'd63, size: 3'd2, burst: 2'd1});
        rcnt1 = 0;
        start_phase();
        k = 0;
        do begin
            @(negedge clk);
            #1;
            k++;
        end while (rcnt1 < 20 && k < 400);
        chk("pre_rst_state", {grant_id, busy, proto_err, k < 400}, 4'b1111);
        #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_outs", {axi_arvalid, axi_rready, m0_arready, m1_arready, m0_rvalid, m1_rvalid,
                             m0_rlast, m1_rlast, axi_araddr, busy, grant_id, proto_err}, '0);
        exp_ar.delete();
        exp_r0.delete();
        exp_r1.delete();
        st_m = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        chk("post_rst_idle", {busy, grant_id, proto_err, axi_arvalid}, '0);

        // randomized traffic
        for (int p = 0; p < 8; p++) begin
            ar_delay = $urandom_range(3);
            rv_pct = $urandom_range(100, 40);
            rr_pct = $urandom_range(100, 40);
            k = $urandom_range(5);
            for (int i = 0; i < k; i++) pend0.push_back(rnd_req(15));
            k = $urandom_range(5);
            for (int i = 0; i < k; i++) pend1.push_back(rnd_req(15));
            start_phase();
            wait_idle("random");
            chk("random_err", {proto_err, busy}, 2'b00);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
